hr_node: RTL and testbench

//  Hierarchical-ring router node on two unidirectional rings (ring 0, ring 1); flits flow port*_i -> port*_o.
//  - Per ring: flits addressed to this node eject to that ring's local port.
//  - Passing traffic is forwarded.
//  - The local port may inject into a free ring slot.
//  - All ring and local outputs are registered (one pipeline stage per hop).

---
 rtl/hr_node.sv | 85 ++++++++
 tb/tb_hr_node.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/hr_node.sv
// Hierarchical-ring router node with two independent unidirectional rings.
// For each ring, a valid flit addressed to this node is ejected to the local port.
// Other valid ring traffic is forwarded, and the local port may inject into a free slot.
// Ring traffic always wins over injection. Every flit output is registered, so each hop costs one
// clock. The injection acks are combinational.
module hr_node #(
  parameter logic [3:0] addr = 4'b0010
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [143:0] port0_i,
  input  logic [143:0] port1_i,
  input  logic [143:0] port0_local_i,
  input  logic [143:0] port1_local_i,
  output logic [143:0] port0_o,
  output logic [143:0] port1_o,
  output logic [143:0] port0_local_o,
  output logic [143:0] port1_local_o,
  output logic         portl0_ack,
  output logic         portl1_ack
);

  localparam int unsigned FlitW    = 144;
  localparam int unsigned ValidBit = 12;

  logic [FlitW-1:0] ring_in  [2];
  logic [FlitW-1:0] local_in [2];
  logic [FlitW-1:0] ring_q   [2];
  logic [FlitW-1:0] eject_q  [2];
  logic             ack      [2];

  assign ring_in[0]  = port0_i;
  assign ring_in[1]  = port1_i;
  assign local_in[0] = port0_local_i;
  assign local_in[1] = port1_local_i;

  for (genvar n = 0; n < 2; n++) begin : g_ring
    logic             in_valid;
    logic             local_valid;
    logic             eject;
    logic             slot_free;
    logic [FlitW-1:0] ring_d;
    logic [FlitW-1:0] eject_d;

    // Per-ring eject/forward/inject decision for the flit currently on the input.
    always_comb begin
      in_valid    = ring_in[n][ValidBit];
      local_valid = local_in[n][ValidBit];
      eject       = in_valid && (ring_in[n][3:0] == addr);
      // An ejecting flit vacates its slot, so injection can share the same edge.
      slot_free   = !in_valid || eject;
      // rst gating keeps the ack low while the node is held in reset.
      ack[n]      = rst && local_valid && slot_free;
      ring_d      = '0;
      eject_d     = '0;
      if (in_valid && !eject) begin
        ring_d = ring_in[n];
      end else if (ack[n]) begin
        ring_d = local_in[n];
      end
      if (eject) begin
        eject_d = ring_in[n];
      end
    end

    // Output pipeline stage; async clear so outputs drop to zero without a clock.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        ring_q[n]  <= '0;
        eject_q[n] <= '0;
      end else begin
        ring_q[n]  <= ring_d;
        eject_q[n] <= eject_d;
      end
    end
  end

  assign port0_o       = ring_q[0];
  assign port1_o       = ring_q[1];
  assign port0_local_o = eject_q[0];
  assign port1_local_o = eject_q[1];
  assign portl0_ack    = ack[0];
  assign portl1_ack    = ack[1];

endmodule

// File: tb/tb_hr_node.sv
// Self-checking bench for hr_node: directed scenarios followed by randomized traffic,
// compared against a small behavioural model of one ring slot.
module tb_hr_node;

  localparam logic [3:0] Addr = 4'b0010;

  logic         clk;
  logic         rst;
  logic [143:0] port0_i, port1_i, port0_local_i, port1_local_i;
  logic [143:0] port0_o, port1_o, port0_local_o, port1_local_o;
  logic         portl0_ack, portl1_ack;

  int n_checks = 0;
  int n_fail   = 0;

  hr_node #(.addr(Addr)) dut (
    .clk           (clk),
    .rst           (rst),
    .port0_i       (port0_i),
    .port1_i       (port1_i),
    .port0_local_i (port0_local_i),
    .port1_local_i (port1_local_i),
    .port0_o       (port0_o),
    .port1_o       (port1_o),
    .port0_local_o (port0_local_o),
    .port1_local_o (port1_local_o),
    .portl0_ack    (portl0_ack),
    .portl1_ack    (portl1_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [127:0] Pay = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE;

  task automatic check(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One ring slot: a valid flit for us leaves the ring; a valid flit for someone else keeps
  // its slot; otherwise the slot may take the local flit.
  function automatic void model(input logic [143:0] rin, input logic [143:0] lin,
                                output logic [143:0] rout, output logic [143:0] lout,
                                output logic ack);
    logic for_us, passing;
    for_us  = rin[12] && (rin[3:0] == Addr);
    passing = rin[12] && !for_us;
    ack     = lin[12] && !passing;
    lout    = for_us ? rin : 144'h0;
    rout    = passing ? rin : (ack ? lin : 144'h0);
  endfunction

  logic [143:0] exp_r0, exp_r1, exp_l0, exp_l1;
  logic         exp_a0, exp_a1;

  // Apply inputs, check acks before the edge, then check registered outputs after it.
  task automatic cycle(input logic [143:0] r0, input logic [143:0] r1,
                       input logic [143:0] l0, input logic [143:0] l1);
    port0_i = r0; port1_i = r1; port0_local_i = l0; port1_local_i = l1;
    model(r0, l0, exp_r0, exp_l0, exp_a0);
    model(r1, l1, exp_r1, exp_l1, exp_a1);
    #1;
    check("ack0", {143'h0, portl0_ack}, {143'h0, exp_a0});
    check("ack1", {143'h0, portl1_ack}, {143'h0, exp_a1});
    @(posedge clk);
    #1;
    check("port0_o", port0_o, exp_r0);
    check("port1_o", port1_o, exp_r1);
    check("port0_local_o", port0_local_o, exp_l0);
    check("port1_local_o", port1_local_o, exp_l1);
  endtask

  function automatic logic [143:0] rand_flit();
    logic [143:0] f;
    f = {$urandom(), $urandom(), $urandom(), $urandom(), 16'h0};
    f[15:13] = 3'($urandom());
    f[12]    = ($urandom_range(0, 3) != 0);
    f[11:8]  = 4'($urandom());
    f[7:4]   = 4'($urandom());
    f[3:0]   = ($urandom_range(0, 2) == 0) ? Addr : 4'($urandom());
    return f;
  endfunction

  function automatic logic [143:0] fl(input logic [15:0] lo);
    return {Pay, lo};
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_p0"}, port0_o, 144'h0);
    check({tag, "_p1"}, port1_o, 144'h0);
    check({tag, "_l0"}, port0_local_o, 144'h0);
    check({tag, "_l1"}, port1_local_o, 144'h0);
    check({tag, "_a0"}, {143'h0, portl0_ack}, 144'h0);
    check({tag, "_a1"}, {143'h0, portl1_ack}, 144'h0);
  endtask

  logic [143:0] pend0, pend1;

  initial begin
    rst = 1'b0;
    port0_i = '0; port1_i = '0; port0_local_i = fl(16'h1855); port1_local_i = '0;
    #2;
    check_all_zero("reset");
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // 1: eject and inject on ring 0 in the same cycle
    cycle(fl(16'h1852), 144'h0, fl(16'h1855), 144'h0);
    check("t1_eject", port0_local_o, fl(16'h1852));
    check("t1_inject", port0_o, fl(16'h1855));

    // 2: pass-through blocks injection, then the held flit goes in
    cycle(144'h0, fl(16'h1857), 144'h0, fl(16'h1853));
    check("t2_forward", port1_o, fl(16'h1857));
    cycle(144'h0, 144'h0, 144'h0, fl(16'h1853));
    check("t2_inject", port1_o, fl(16'h1853));

    // 3: empty ring, inject
    cycle(144'h0, 144'h0, fl(16'h1413), 144'h0);
    check("t3_inject", port0_o, fl(16'h1413));

    // 4: both rings eject together
    cycle(fl(16'h1A32), fl(16'h1B42), 144'h0, 144'h0);
    check("t4_l0", port0_local_o, fl(16'h1A32));
    check("t4_l1", port1_local_o, fl(16'h1B42));

    // 6: invalid flit for our address is dropped
    cycle(fl(16'h0852), fl(16'h0852), fl(16'h0855), 144'h0);

    // 5: asynchronous reset mid-traffic
    cycle(fl(16'h1857), fl(16'h1852), fl(16'h1855), fl(16'h1855));
    #1;
    rst = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    rst = 1'b1;
    cycle(fl(16'h1852), 144'h0, fl(16'h1855), 144'h0);
    check("t5_eject", port0_local_o, fl(16'h1852));

    // Randomized traffic; local sources hold their flit until acked.
    pend0 = rand_flit();
    pend1 = rand_flit();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      cycle(rand_flit(), rand_flit(), pend0, pend1);
      if (exp_a0 || !pend0[12]) pend0 = rand_flit();
      if (exp_a1 || !pend1[12]) pend1 = rand_flit();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
